// File: rtl/ex_muldiv_if.sv
// EX <-> multiply/divide sequencer handshake: operation request, flush,
// and the stall/done/result response.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1_data, rs2_data, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply and restoring divide
// on magnitudes, with sign fix-up, divide-by-zero and overflow handled at FIN.
module ex_muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_muldiv_if.slave   md
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return '0 - v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return '0 - v;
  endfunction

  function automatic logic [XLEN-1:0] sign_fix(input logic neg, input logic [XLEN-1:0] v);
    return neg ? neg_x(v) : v;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] prod_q;
  logic              neg_q, rneg_q, dz_q, ovf_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   result_q;

  logic accept, step, done, stall;

  // Operand conditioning for the incoming request
  logic            s1_signed, s2_signed, n1, n2, is_div, dz, ovf;
  logic [XLEN-1:0] abs1, abs2;

  always_comb begin
    s1_signed = md.op[2] ? ~md.op[0] : (md.op[1:0] != 2'b11);
    s2_signed = md.op[2] ? ~md.op[0] : ~md.op[1];
    n1        = s1_signed & md.rs1_data[XLEN-1];
    n2        = s2_signed & md.rs2_data[XLEN-1];
    abs1      = sign_fix(n1, md.rs1_data);
    abs2      = sign_fix(n2, md.rs2_data);
    is_div    = md.op[2];
    dz        = is_div & (md.rs2_data == '0);
    ovf       = is_div & ~md.op[0] & (md.rs1_data == MIN_NEG) & (md.rs2_data == '1);
  end

  // One iteration: multiply keeps the multiplier in the low half and shifts
  // it out; divide keeps {remainder, dividend/quotient} in the same register.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_d;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = prod_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!op_q[2])
      prod_d = {mul_sum, prod_q[XLEN-1:1]};
    else if (!div_diff[XLEN])
      prod_d = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    else
      prod_d = {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   fin_val;

  always_comb begin
    prod_s  = neg_q ? neg_2x(prod_q) : prod_q;
    fin_val = '0;
    unique case (op_q)
      OP_MUL:                       fin_val = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_val = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:
        fin_val = dz_q ? '1 : ovf_q ? MIN_NEG : sign_fix(neg_q, prod_q[XLEN-1:0]);
      OP_REM, OP_REMU:
        fin_val = dz_q ? rs1_q : ovf_q ? '0 : sign_fix(rneg_q, prod_q[2*XLEN-1:XLEN]);
      default:                      fin_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    done    = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (md.start && !md.flush) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = (dz || ovf) ? S_FIN : S_CALC;
        end
      end
      S_CALC: begin
        stall = 1'b1;
        if (md.flush) begin
          state_d = S_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIN;
        end
      end
      S_FIN: begin
        done    = ~md.flush;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      rs1_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        cnt_q  <= '0;
        op_q   <= md.op;
        opnd_q <= is_div ? abs2 : abs1;
        prod_q <= {{XLEN{1'b0}}, (is_div ? abs1 : abs2)};
        neg_q  <= n1 ^ n2;
        rneg_q <= n1;
        dz_q   <= dz;
        ovf_q  <= ovf;
        rs1_q  <= md.rs1_data;
      end else if (step) begin
        prod_q <= prod_d;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      if (done) result_q <= fin_val;
    end
  end

  assign md.busy   = (state_q != S_IDLE);
  assign md.stall  = stall;
  assign md.done   = done;
  assign md.result = done ? fin_val : result_q;

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
Iterative RV32M multiply/divide sequencer attached to the EX stage. It accepts an M-extension operation from EX, runs a radix-2 shift-add / restoring-divide loop over XLEN cycles, and holds the pipeline via stall until the result is ready. On the done cycle, EX selects its result in place of the ALU sum. Sign handling, divide-by-zero and overflow are resolved here so that EX stays combinational.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  EX holds a valid M-extension op this cycle
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  XLEN  operand A (multiplicand / dividend)
rs2_data  input  XLEN  operand B (multiplier / divisor)
flush  input  1  pipeline flush (branch mispredict); aborts the operation
busy  output  1  operation in progress (state != IDLE)
stall  output  1  freeze IF/ID/EX pipeline registers
done  output  1  one-cycle pulse; result valid
result  output  XLEN  final result; holds its value until the next done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, stall=0, done=0, result=0; counter and accumulators cleared. Deasserting rst_n mid-operation is a full abort, with no done.
- States:
  - IDLE: waits for start.
  - CALC: iterating.
  - FIN: sign fix and result latch; done=1 in this state.
- IDLE:
  - start=1 and flush=0: latch op, take absolute values of the operands per signedness, and record the result sign.
    - MUL/MULH: both operands signed. MULHSU: rs1 signed only. MULHU, DIVU, REMU: unsigned.
    - Normal path → CALC with counter=0.
    - Fast path → FIN directly: divide with rs2=0, or signed DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF.
  - start while flush=1: ignored.
- CALC, one iteration per cycle:
  - Multiply: 2*XLEN-bit product accumulator.
  - Divide: restoring shift-subtract, quotient and remainder registers.
  - Counter increments each cycle. After XLEN cycles (counter==XLEN-1), → FIN.
- FIN: done=1 and result is registered; the next cycle → IDLE.
  - MUL: low half of the product.
  - MULH*: high half of the signed-corrected product.
  - DIV/DIVU: quotient, negated if the signs differ (DIV only).
  - REM/REMU: remainder, with the dividend's sign (REM only).
  - Divide-by-zero: quotient=all ones; remainder=rs1.
  - Overflow: quotient=0x80000000; remainder=0.
- Latency (start sampled at edge T):
  - Normal path: done at cycle T+XLEN+1 (T+33).
  - Fast path: done at T+1.
- stall: combinational, = (state==IDLE & start & ~flush) | (state==CALC). It is low during FIN, so EX advances with the result in the done cycle.
- busy = (state != IDLE).
- flush in CALC or FIN: → IDLE next edge; done is suppressed and result is unchanged.
- flush takes priority over start in the same cycle.
- start while busy: ignored; operands are not resampled.
- Back-to-back operations: a new start is accepted in the cycle after FIN (IDLE). There is no overlap.
- Operand widths: all internal arithmetic is XLEN+1 or 2*XLEN wide, and negation is two's complement mod 2^XLEN.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, start at T → stall=1 T..T+32, done=1 at T+33, result=0xFFFFFFEB; busy=0 at T+34.
- MULH 0x80000000*0x80000000 → 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 → 0xFFFFFFFF.
- DIVU 100/7 → 14 and REMU → 2. DIV 0xFFFFFFF9/2 → 0xFFFFFFFD and REM → 0xFFFFFFFF.
- DIV 5/0 → 0xFFFFFFFF with done at T+1; REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1; REM of the same operands → 0.
- Start DIVU, assert flush at T+10 → IDLE at T+11, no done, result holds its prior value. A start at T+5 while busy → ignored.
- Reset: drop rst_n asynchronously mid-CALC → all outputs 0 immediately; after release, a new MUL 3*4 → 12 at +33 cycles.
